// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates RISC-V conditional branches and jumps,
// computes the next-PC target, flags mispredictions and trains a
// pattern history table of 2-bit saturating counters.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake
//   br_type                  000 none, 001 BEQ, 010 BNE, 011 BLT,
//                            100 BGE, 101 BLTU, 110 BGEU, 111 jump
//   rdata1, rdata2           compare operands
//   pc, imm                  branch PC and offset
//   pred_in                  prediction issued earlier for this branch
//   out_valid / out_ready    downstream handshake
//   br_taken, br_target,
//   mispredict               registered result (latency 1)
//   lookup_pc / lookup_taken combinational PHT prediction port
//   stat_branches,
//   stat_mispredicts         saturating counters, only with BRU_STATS_EN
//
// Optional feature macro: BRU_STATS_EN (adds the two statistics outputs).

module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int PHT_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      br_type,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic            mispredict,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    localparam logic [2:0] BT_NONE = 3'b000;
    localparam logic [2:0] BT_BEQ  = 3'b001;
    localparam logic [2:0] BT_BNE  = 3'b010;
    localparam logic [2:0] BT_BLT  = 3'b011;
    localparam logic [2:0] BT_BGE  = 3'b100;
    localparam logic [2:0] BT_BLTU = 3'b101;
    localparam logic [2:0] BT_BGEU = 3'b110;
    localparam logic [2:0] BT_JUMP = 3'b111;

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
        logic            mispredict;
    } result_t;

    result_t          res_q;
    result_t          res_d;
    logic             valid_q;
    logic             accept;
    logic             is_cond;
    logic             taken_c;
    logic             eq;
    logic             lt_s;
    logic             lt_u;
    logic [1:0]       pht [PHT_DEPTH];
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lkp_idx;
    logic             unused_bits;

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    assign in_ready = !valid_q || out_ready;
    // Reset blocks acceptance even if in_valid is high.
    assign accept   = in_valid && in_ready && !rst;

    // ---------------------------------------------------------------
    // Branch evaluation
    // ---------------------------------------------------------------
    assign eq   = (rdata1 == rdata2);
    assign lt_s = ($signed(rdata1) < $signed(rdata2));
    assign lt_u = (rdata1 < rdata2);

    always_comb begin
        taken_c = 1'b0;
        unique case (1'b1)
            (br_type == BT_BEQ):  taken_c = eq;
            (br_type == BT_BNE):  taken_c = !eq;
            (br_type == BT_BLT):  taken_c = lt_s;
            (br_type == BT_BGE):  taken_c = !lt_s;
            (br_type == BT_BLTU): taken_c = lt_u;
            (br_type == BT_BGEU): taken_c = !lt_u;
            (br_type == BT_JUMP): taken_c = 1'b1;
            default:              taken_c = 1'b0;
        endcase
    end

    // Only real conditional branches train the predictor.
    assign is_cond = (br_type != BT_NONE) && (br_type != BT_JUMP);

    always_comb begin
        res_d            = '0;
        res_d.taken      = taken_c;
        res_d.target     = taken_c ? (pc + imm) : (pc + XLEN'(4));
        res_d.mispredict = (br_type != BT_NONE) && (pred_in != taken_c);
    end

    // ---------------------------------------------------------------
    // Result register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            res_q   <= res_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid  = valid_q;
    assign br_taken   = res_q.taken;
    assign br_target  = res_q.target;
    assign mispredict = res_q.mispredict;

    // ---------------------------------------------------------------
    // Pattern history table
    // ---------------------------------------------------------------
    assign upd_idx = pc[IDX_W+1:2];
    assign lkp_idx = lookup_pc[IDX_W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (accept && is_cond) begin
            if (taken_c) begin
                if (pht[upd_idx] != 2'b11) begin
                    pht[upd_idx] <= pht[upd_idx] + 2'b01;
                end
            end else begin
                if (pht[upd_idx] != 2'b00) begin
                    pht[upd_idx] <= pht[upd_idx] - 2'b01;
                end
            end
        end
    end

    // Reads the stored counter, so a same-cycle update is not visible yet.
    assign lookup_taken = pht[lkp_idx][1];

    // Only the index field of lookup_pc selects an entry.
    assign unused_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

    // ---------------------------------------------------------------
    // Optional statistics
    // ---------------------------------------------------------------
`ifdef BRU_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (accept) begin
            if (br_type != BT_NONE && stat_branches != '1) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (res_d.mispredict && stat_mispredicts != '1) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table,
// hand-written multi-cycle sequences and a randomized model comparison.

module tb_branch_resolve_unit;

    localparam int XLEN      = 32;
    localparam int PHT_DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      br_type;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            pred_in;
    logic            out_valid;
    logic            out_ready;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            mispredict;
    logic [XLEN-1:0] lookup_pc;
    logic            lookup_taken;
`ifdef BRU_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
`endif

    branch_resolve_unit #(
        .XLEN      (XLEN),
        .PHT_DEPTH (PHT_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .br_type      (br_type),
        .rdata1       (rdata1),
        .rdata2       (rdata2),
        .pc           (pc),
        .imm          (imm),
        .pred_in      (pred_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .mispredict   (mispredict),
        .lookup_pc    (lookup_pc),
        .lookup_taken (lookup_taken)
`ifdef BRU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] bt, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p,
                         input logic [31:0] i, input logic pr);
        br_type  = bt;
        rdata1   = a;
        rdata2   = b;
        pc       = p;
        imm      = i;
        pred_in  = pr;
        in_valid = 1'b1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic check_pht_cleared(input string name);
        for (int k = 0; k < PHT_DEPTH; k++) begin
            lookup_pc = 32'(k) << 2;
            #1;
            check(name, lookup_taken, 0);
        end
    endtask

    // Reference rules straight from the branch definitions.
    function automatic logic ref_taken(input logic [2:0] bt,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        case (bt)
            3'd1:    return a == b;
            3'd2:    return a != b;
            3'd3:    return int'(a) < int'(b);
            3'd4:    return int'(a) >= int'(b);
            3'd5:    return longint'(a) < longint'(b);
            3'd6:    return longint'(a) >= longint'(b);
            3'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input logic t,
                                               input logic [31:0] p,
                                               input logic [31:0] i);
        longint sum;
        sum = longint'(p) + (t ? longint'(i) : 64'd4);
        return 32'(sum % 64'h1_0000_0000);
    endfunction

    typedef struct {
        logic [2:0]  bt;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] p;
        logic [31:0] i;
        logic        pr;
        logic        et;
        logic [31:0] etgt;
        logic        em;
        string       name;
    } vec_t;

    vec_t vecs[8];

    // Model state for the random phase
    int          m_pht[PHT_DEPTH];
    logic        m_valid;
    logic        m_taken;
    logic [31:0] m_tgt;
    logic        m_mis;
    longint      m_nbr;
    longint      m_nmis;

    initial begin
        vecs[0] = '{3'd3, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 1'b0,
                    1'b1, 32'h120, 1'b1, "blt_neg"};
        vecs[1] = '{3'd5, 32'hFFFFFFFF, 32'h1, 32'h100, 32'h20, 1'b0,
                    1'b0, 32'h104, 1'b0, "bltu_big"};
        vecs[2] = '{3'd1, 32'h5, 32'h5, 32'h200, 32'h8, 1'b1,
                    1'b1, 32'h208, 1'b0, "beq_eq"};
        vecs[3] = '{3'd2, 32'h5, 32'h5, 32'h200, 32'h8, 1'b1,
                    1'b0, 32'h204, 1'b1, "bne_eq"};
        vecs[4] = '{3'd4, 32'h80000000, 32'h7FFFFFFF, 32'h300, 32'hFFFFFFFC,
                    1'b0, 1'b0, 32'h304, 1'b0, "bge_neg"};
        vecs[5] = '{3'd6, 32'h80000000, 32'h7FFFFFFF, 32'h300, 32'hFFFFFFFC,
                    1'b0, 1'b1, 32'h2FC, 1'b1, "bgeu_big"};
        vecs[6] = '{3'd7, 32'h0, 32'h0, 32'hFFFFFFF0, 32'h20, 1'b1,
                    1'b1, 32'h10, 1'b0, "jump_wrap"};
        vecs[7] = '{3'd0, 32'h3, 32'h3, 32'h10, 32'h40, 1'b1,
                    1'b0, 32'h14, 1'b0, "none"};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        br_type   = '0;
        rdata1    = '0;
        rdata2    = '0;
        pc        = '0;
        imm       = '0;
        pred_in   = 1'b0;
        lookup_pc = '0;

        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_taken", br_taken, 0);
        check("rst_target", br_target, 0);
        check("rst_mispredict", mispredict, 0);
        check("rst_in_ready", in_ready, 1);
        check_pht_cleared("rst_pht");
`ifdef BRU_STATS_EN
        check("rst_stat_br", stat_branches, 0);
        check("rst_stat_mis", stat_mispredicts, 0);
`endif

        // Vector table, back to back with no bubble
        for (int v = 0; v < 8; v++) begin
            drive(vecs[v].bt, vecs[v].r1, vecs[v].r2, vecs[v].p,
                  vecs[v].i, vecs[v].pr);
            check({vecs[v].name, "_ready"}, in_ready, 1);
            step();
            check({vecs[v].name, "_valid"}, out_valid, 1);
            check({vecs[v].name, "_taken"}, br_taken, vecs[v].et);
            check({vecs[v].name, "_target"}, br_target, vecs[v].etgt);
            check({vecs[v].name, "_mis"}, mispredict, vecs[v].em);
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", out_valid, 0);

        // PHT training at one index
        do_reset();
        lookup_pc = 32'h40;
        #1;
        check("pht_init", lookup_taken, 0);
        drive(3'd1, 32'h9, 32'h9, 32'h40, 32'h4, 1'b0);
        #1;
        check("pht_same_cycle", lookup_taken, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("pht_taken", lookup_taken, 1);
        end
        drive(3'd1, 32'h9, 32'h8, 32'h40, 32'h4, 1'b1);
        step();
        check("pht_nt1", lookup_taken, 1);
        step();
        check("pht_nt2", lookup_taken, 0);
        step();
        check("pht_nt3", lookup_taken, 0);
        step();
        check("pht_nt4", lookup_taken, 0);
        in_valid = 1'b0;
        step();

        // Backpressure: hold result for 3 cycles, then drain and accept
        out_ready = 1'b0;
        drive(3'd3, 32'h1, 32'h2, 32'h80, 32'h10, 1'b0);
        step();
        check("bp_valid", out_valid, 1);
        check("bp_ready", in_ready, 0);
        drive(3'd1, 32'h7, 32'h7, 32'h84, 32'h8, 1'b1);
        lookup_pc = 32'h84;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_taken", br_taken, 1);
            check("bp_hold_target", br_target, 32'h90);
            check("bp_hold_mis", mispredict, 1);
            check("bp_hold_pht", lookup_taken, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        step();
        check("bp_next_valid", out_valid, 1);
        check("bp_next_target", br_target, 32'h8C);
        check("bp_next_mis", mispredict, 0);
        check("bp_next_pht", lookup_taken, 1);
        in_valid = 1'b0;
        step();
        check("bp_empty", out_valid, 0);

        // Jump with wrap-around leaves the PHT alone
        lookup_pc = 32'hFFFFFFF0;
        #1;
        check("jmp_pht_before", lookup_taken, 0);
        drive(3'd7, 32'h0, 32'h1, 32'hFFFFFFF0, 32'h20, 1'b0);
        step();
        in_valid = 1'b0;
        check("jmp_taken", br_taken, 1);
        check("jmp_target", br_target, 32'h10);
        check("jmp_mis", mispredict, 1);
        check("jmp_pht_after", lookup_taken, 0);
        step();

        // Reset while a result is held; in_valid high during reset
        out_ready = 1'b0;
        drive(3'd2, 32'h1, 32'h2, 32'h84, 32'h8, 1'b0);
        step();
        check("rh_valid", out_valid, 1);
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rh_out_valid", out_valid, 0);
        check("rh_taken", br_taken, 0);
        check("rh_target", br_target, 0);
        check("rh_mis", mispredict, 0);
        check_pht_cleared("rh_pht");
`ifdef BRU_STATS_EN
        check("rh_stat_br", stat_branches, 0);
        check("rh_stat_mis", stat_mispredicts, 0);
`endif

        // Randomized run against the model
        do_reset();
        for (int k = 0; k < PHT_DEPTH; k++) m_pht[k] = 1;
        m_valid = 1'b0;
        m_taken = 1'b0;
        m_tgt   = '0;
        m_mis   = 1'b0;
        m_nbr   = 0;
        m_nmis  = 0;
        for (int c = 0; c < 400; c++) begin
            logic        exp_ready;
            logic        t;
            int          li;
            int          ui;
            logic [31:0] a;
            a = $urandom;
            drive(3'($urandom_range(0, 7)), a,
                  ($urandom_range(0, 2) == 0) ? a : $urandom,
                  ($urandom & 32'hFFFF0000) | (32'($urandom_range(0, 15)) << 2),
                  $urandom, 1'($urandom_range(0, 1)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            lookup_pc = ($urandom & 32'hFFFF0003) |
                        (32'($urandom_range(0, 15)) << 2);
            #1;
            exp_ready = !m_valid || out_ready;
            li = int'(lookup_pc[7:2]);
            check("rnd_ready", in_ready, exp_ready);
            check("rnd_lookup", lookup_taken, m_pht[li] >= 2);
            if (in_valid && exp_ready) begin
                t       = ref_taken(br_type, rdata1, rdata2);
                m_valid = 1'b1;
                m_taken = t;
                m_tgt   = ref_target(t, pc, imm);
                m_mis   = (br_type != 0) && (pred_in != t);
                ui      = int'(pc[7:2]);
                if (br_type != 0 && br_type != 7) begin
                    if (t && m_pht[ui] < 3) m_pht[ui]++;
                    if (!t && m_pht[ui] > 0) m_pht[ui]--;
                end
                if (br_type != 0) m_nbr++;
                if (m_mis) m_nmis++;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            step();
            check("rnd_valid", out_valid, m_valid);
            if (m_valid) begin
                check("rnd_taken", br_taken, m_taken);
                check("rnd_target", br_target, m_tgt);
                check("rnd_mis", mispredict, m_mis);
            end
`ifdef BRU_STATS_EN
            check("rnd_stat_br", stat_branches, 64'(m_nbr));
            check("rnd_stat_mis", stat_mispredicts, 64'(m_nmis));
`endif
        end
        in_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
